// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants, state encoding and bit-timing helper for the serial command link.
package uart_cmd_pkg;
    localparam int WORD_W_DEF = 32;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState_t;
    function automatic int bitCyc(input int clkFreq, input int baud);
        return (clkFreq + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/cmd_sync_fifo.sv
// cmd_sync_fifo: single-clock command FIFO, normal (registered read) mode with registered flags.
module cmd_sync_fifo
    import uart_cmd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W = WORD_W_DEF
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [W-1:0]               wrData,
    input  logic                       wrReq,
    input  logic                       rdReq,
    output logic [W-1:0]               rdData,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     usedW
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic wrOk, rdOk;
    logic [AW:0] usedNext;
    // a full FIFO still takes a write when a read frees the slot in the same cycle
    assign wrOk = wrReq && (!full || rdReq);
    assign rdOk = rdReq && !empty;
    assign usedNext = usedW + (AW+1)'(wrOk) - (AW+1)'(rdOk);
    always_ff @(posedge CLK)
        if (!reset && wrOk) mem[wrPtr] <= wrData;
    always_ff @(posedge CLK) begin
        if (reset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            rdData <= '0;
            usedW  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wrOk) wrPtr <= wrPtr + AW'(1);
            if (rdOk) begin
                rdData <= mem[rdPtr];
                rdPtr  <= rdPtr + AW'(1);
            end
            usedW <= usedNext;
            empty <= usedNext == '0;
            full  <= usedNext == (AW+1)'(DEPTH);
        end
    end
endmodule

// File: rtl/uart_cmd_link.sv
// uart_cmd_link: 8N1 UART RX/TX plus command FIFO for the motor-control front-end.
// Define UART_FRAME_ERR_EN to add the rx_frame_err pulse output.
module uart_cmd_link
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ   = 24000000,
    parameter int BAUD       = 230400,
    parameter int FIFO_DEPTH = 16,
    parameter int WORD_W     = WORD_W_DEF
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_data_ready,
`ifdef UART_FRAME_ERR_EN
    output logic                          rx_frame_err,
`endif
    output logic                          txd,
    input  logic                          tx_start,
    input  logic [7:0]                    tx_data,
    output logic                          tx_busy,
    input  logic [WORD_W-1:0]             fifo_data,
    input  logic                          fifo_wrreq,
    input  logic                          fifo_rdreq,
    output logic [WORD_W-1:0]             fifo_q,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_usedw
);
    localparam int BIT_CYC  = bitCyc(CLK_FREQ, BAUD);
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CYC - 1);

    logic rxMeta, rxSync, rxPrev;
    uartState_t rxState;
    logic [15:0] rxCnt;
    logic [2:0] rxBit;
    logic [7:0] rxShift;
    always_ff @(posedge CLK) begin
        if (reset) begin
            rxMeta        <= 1'b1;
            rxSync        <= 1'b1;
            rxPrev        <= 1'b1;
            rxState       <= IDLE;
            rxCnt         <= '0;
            rxBit         <= '0;
            rxShift       <= '0;
            rx_data       <= '0;
            rx_data_ready <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            rx_frame_err  <= 1'b0;
`endif
        end else begin
            rxMeta        <= rxd;
            rxSync        <= rxMeta;
            rxPrev        <= rxSync;
            rx_data_ready <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            rx_frame_err  <= 1'b0;
`endif
            rxCnt <= rxCnt + 16'd1;
            case (rxState)
                IDLE: begin
                    rxCnt <= '0;
                    if (rxPrev && !rxSync) rxState <= START;
                end
                START: if (rxCnt == HALF_LAST) begin
                    rxCnt   <= '0;
                    rxBit   <= '0;
                    rxState <= rxSync ? IDLE : DATA;
                end
                DATA: if (rxCnt == BIT_LAST) begin
                    rxCnt   <= '0;
                    rxShift <= {rxSync, rxShift[7:1]};
                    rxBit   <= rxBit + 3'd1;
                    if (rxBit == 3'd7) rxState <= STOP;
                end
                STOP: if (rxCnt == BIT_LAST) begin
                    rxCnt   <= '0;
                    rxState <= IDLE;
                    if (rxSync) begin
                        rx_data       <= rxShift;
                        rx_data_ready <= 1'b1;
                    end
`ifdef UART_FRAME_ERR_EN
                    rx_frame_err <= !rxSync;
`else
                    // a low stop bit just drops the byte
`endif
                end
                default: rxState <= IDLE;
            endcase
        end
    end

    uartState_t txState;
    logic [15:0] txCnt;
    logic [2:0] txBit;
    logic [7:0] txShift;
    always_ff @(posedge CLK) begin
        if (reset) begin
            txState <= IDLE;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            txCnt   <= '0;
            txBit   <= '0;
            txShift <= '0;
        end else begin
            txCnt <= txCnt + 16'd1;
            case (txState)
                IDLE: begin
                    txCnt <= '0;
                    if (tx_start) begin
                        txShift <= tx_data;
                        txd     <= 1'b0;
                        tx_busy <= 1'b1;
                        txState <= START;
                    end
                end
                START: if (txCnt == BIT_LAST) begin
                    txCnt   <= '0;
                    txBit   <= '0;
                    txd     <= txShift[0];
                    txShift <= {1'b0, txShift[7:1]};
                    txState <= DATA;
                end
                DATA: if (txCnt == BIT_LAST) begin
                    txCnt   <= '0;
                    txBit   <= txBit + 3'd1;
                    txd     <= txBit == 3'd7 ? 1'b1 : txShift[0];
                    txShift <= {1'b0, txShift[7:1]};
                    if (txBit == 3'd7) txState <= STOP;
                end
                STOP: if (txCnt == BIT_LAST) begin
                    txCnt <= '0;
                    // a held request chains the next frame with no idle gap
                    if (tx_start) begin
                        txShift <= tx_data;
                        txd     <= 1'b0;
                        txState <= START;
                    end else begin
                        tx_busy <= 1'b0;
                        txState <= IDLE;
                    end
                end
                default: txState <= IDLE;
            endcase
        end
    end

    cmd_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) fifo (
        .CLK    (CLK),
        .reset  (reset),
        .wrData (fifo_data),
        .wrReq  (fifo_wrreq),
        .rdReq  (fifo_rdreq),
        .rdData (fifo_q),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .usedW  (fifo_usedw)
    );
endmodule

// File: tb/tb_uart_cmd_link.sv
// tb_uart_cmd_link: directed self-checking bench for uart_cmd_link (default 24 MHz / 230400 baud).
module tb_uart_cmd_link;
    localparam int BIT = 104;
    logic CLK = 1'b0;
    logic reset, rxd, tx_start, fifo_wrreq, fifo_rdreq;
    logic [7:0] tx_data, rx_data;
    logic rx_data_ready, txd, tx_busy, fifo_empty, fifo_full;
    logic [31:0] fifo_data, fifo_q;
    logic [4:0] fifo_usedw;
`ifdef UART_FRAME_ERR_EN
    logic rx_frame_err;
    int feCount = 0;
`endif
    int asserts = 0, fails = 0, cyc = 0, rxPulses = 0, busyCycles = 0, pulseCyc = 0;
    int p0, s0;
    logic [7:0] lastRx = 8'h00;
    logic [9:0] txExp = 10'b1_0100_1111_0;

    uart_cmd_link dut (
        .CLK(CLK), .reset(reset), .rxd(rxd), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
`ifdef UART_FRAME_ERR_EN
        .rx_frame_err(rx_frame_err),
`endif
        .txd(txd), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_usedw(fifo_usedw)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        cyc++;
        if (rx_data_ready) begin
            rxPulses++;
            lastRx = rx_data;
            pulseCyc = cyc;
        end
        if (tx_busy) busyCycles++;
`ifdef UART_FRAME_ERR_EN
        if (rx_frame_err) feCount++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sendRx(input logic [7:0] b, input logic stopBit);
        rxd = 1'b0;
        repeat (BIT) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge CLK);
        end
        rxd = stopBit;
        repeat (BIT) @(negedge CLK);
        rxd = 1'b1;
    endtask

    task automatic fifoOp(input logic wr, input logic rd, input logic [31:0] d);
        fifo_wrreq = wr;
        fifo_rdreq = rd;
        fifo_data = d;
        @(negedge CLK);
        fifo_wrreq = 1'b0;
        fifo_rdreq = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rxd = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
        fifo_wrreq = 1'b0; fifo_rdreq = 1'b0; fifo_data = '0;
        repeat (5) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check("reset txd", txd, 1);
        check("reset tx_busy", tx_busy, 0);
        check("reset rx_data_ready", rx_data_ready, 0);
        check("reset rx_data", rx_data, 0);
        check("reset fifo_empty", fifo_empty, 1);
        check("reset fifo_full", fifo_full, 0);
        check("reset fifo_usedw", fifo_usedw, 0);
        check("reset fifo_q", fifo_q, 0);

        p0 = rxPulses; s0 = cyc;
        sendRx(8'hA5, 1'b1);
        repeat (20) @(negedge CLK);
        check("rx A5 pulses", rxPulses - p0, 1);
        check("rx A5 pulse data", lastRx, 8'hA5);
        check("rx A5 rx_data", rx_data, 8'hA5);
        check("rx A5 latency ok", (pulseCyc - s0 >= 970 && pulseCyc - s0 <= 1010), 1);

        p0 = rxPulses;
        rxd = 1'b0;
        repeat (40) @(negedge CLK);
        rxd = 1'b1;
        repeat (300) @(negedge CLK);
        check("rx glitch pulses", rxPulses - p0, 0);

        p0 = rxPulses;
        sendRx(8'h3C, 1'b0);
        repeat (20) @(negedge CLK);
        check("rx frame err pulses", rxPulses - p0, 0);
        check("rx frame err data kept", rx_data, 8'hA5);
`ifdef UART_FRAME_ERR_EN
        check("rx_frame_err count", feCount, 1);
`endif

        p0 = rxPulses;
        sendRx(8'h5A, 1'b1);
        sendRx(8'hC3, 1'b1);
        repeat (20) @(negedge CLK);
        check("rx back-to-back pulses", rxPulses - p0, 2);
        check("rx back-to-back data", rx_data, 8'hC3);

        busyCycles = 0;
        tx_data = 8'h4F; tx_start = 1'b1;
        @(negedge CLK);
        tx_start = 1'b0; tx_data = 8'h00;
        @(negedge CLK);
        check("tx busy rises", tx_busy, 1);
        repeat (51) @(negedge CLK);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx bit %0d", k), txd, txExp[k]);
            if (k == 3) begin
                @(negedge CLK);
                tx_start = 1'b1;
                @(negedge CLK);
                tx_start = 1'b0;
                repeat (102) @(negedge CLK);
            end else begin
                repeat (BIT) @(negedge CLK);
            end
        end
        for (int i = 0; i < 200 && tx_busy; i++) @(negedge CLK);
        check("tx busy falls", tx_busy, 0);
        check("tx busy cycles", busyCycles, 1040);
        check("tx idle txd", txd, 1);
        repeat (20) @(negedge CLK);
        check("tx ignored start no refire", tx_busy, 0);

        fifoOp(1, 0, 32'h000AAAAB);
        fifoOp(1, 0, 32'hFFFFFFFB);
        check("fifo usedw 2", fifo_usedw, 2);
        check("fifo not empty", fifo_empty, 0);
        fifoOp(0, 1, 0);
        check("fifo rd1", fifo_q, 32'h000AAAAB);
        fifoOp(0, 1, 0);
        check("fifo rd2", fifo_q, 32'hFFFFFFFB);
        check("fifo empty after rd", fifo_empty, 1);
        check("fifo usedw 0", fifo_usedw, 0);
        fifoOp(0, 1, 0);
        check("fifo rd empty q held", fifo_q, 32'hFFFFFFFB);
        fifoOp(1, 1, 32'h00000077);
        check("fifo wr+rd empty usedw", fifo_usedw, 1);
        check("fifo wr+rd empty q held", fifo_q, 32'hFFFFFFFB);
        fifoOp(0, 1, 0);
        check("fifo rd 77", fifo_q, 32'h00000077);
        check("fifo empty again", fifo_empty, 1);

        for (int i = 0; i < 16; i++) fifoOp(1, 0, 32'h100 + i);
        check("fifo full", fifo_full, 1);
        check("fifo usedw 16", fifo_usedw, 16);
        fifoOp(1, 0, 32'hDEAD);
        check("fifo 17th write dropped", fifo_usedw, 16);
        fifoOp(1, 1, 32'h200);
        check("fifo full wr+rd q", fifo_q, 32'h100);
        check("fifo full wr+rd usedw", fifo_usedw, 16);
        check("fifo full wr+rd full", fifo_full, 1);
        for (int i = 1; i < 17; i++) begin
            fifoOp(0, 1, 0);
            check($sformatf("fifo drain %0d", i), fifo_q, i == 16 ? 32'h200 : 32'h100 + i);
        end
        check("fifo drained empty", fifo_empty, 1);
        check("fifo drained full", fifo_full, 0);

        fifoOp(1, 0, 32'h1234);
        tx_data = 8'hFF; tx_start = 1'b1;
        @(negedge CLK);
        tx_start = 1'b0;
        repeat (300) @(negedge CLK);
        check("tx busy before reset", tx_busy, 1);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        check("mid-frame reset txd", txd, 1);
        check("mid-frame reset tx_busy", tx_busy, 0);
        check("reset fifo_empty again", fifo_empty, 1);
        check("reset fifo_q again", fifo_q, 0);
        repeat (200) @(negedge CLK);
        check("no frame after reset", tx_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
